// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache.
// Holds the control FSM state encoding.
package lc3b_types;

    typedef enum logic [1:0] {
        S_HITMISS   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } cache_state_t;

endpackage

// File: rtl/pmem_wait_timer.sv
// Saturating wait counter for physical-memory transfers.
// Ports: clk, rst_n, active (count), clear (zero), expired (sticky).
module pmem_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Flag latches the moment the count lands on the limit.
        expired_d = expired_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back, write-allocate LC-3b cache.
// Ports: CPU handshake, hit/LRU status in, pmem handshake, datapath loads out.
module cache_control
    import lc3b_types::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_read,
    input  logic mem_write,
    output logic mem_resp,
    input  logic hit0,
    input  logic hit1,
    input  logic lru_bit,
    input  logic lru_dirty,
    input  logic pmem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic pmem_addr_sel,
    output logic lru_or_way,
    output logic way_sel,
    output logic load_data,
    output logic data_src_sel,
    output logic load_tag_valid,
    output logic set_dirty,
    output logic clear_dirty,
    output logic load_lru,
    output logic lru_in,
    output logic pmem_timeout
);

    cache_state_t state_q, state_d;

    logic req;
    logic hit;
    logic hitway;
    logic tmr_active;
    logic tmr_clear;

    // lru_bit steers the external arbitrator; the FSM itself never needs it.
    logic unused_lru_bit;
    assign unused_lru_bit = lru_bit;

    assign req    = mem_read | mem_write;
    assign hit    = hit0 | hit1;
    // Way 0 wins if both ways report a hit.
    assign hitway = hit1 & ~hit0;

    always_comb begin
        state_d        = state_q;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_addr_sel  = 1'b0;
        lru_or_way     = 1'b0;
        way_sel        = 1'b0;
        load_data      = 1'b0;
        data_src_sel   = 1'b0;
        load_tag_valid = 1'b0;
        set_dirty      = 1'b0;
        clear_dirty    = 1'b0;
        load_lru       = 1'b0;
        lru_in         = 1'b0;

        if (!rst_n) begin
            // Keep every load quiet while reset is held.
            lru_or_way = 1'b1;
        end else begin
            unique case (state_q)
                S_HITMISS: begin
                    lru_or_way = 1'b1;
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hitway;
                        if (mem_write) begin
                            way_sel   = hitway;
                            load_data = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else if (req) begin
                        state_d = lru_dirty ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        clear_dirty = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                S_FETCH: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data      = 1'b1;
                        data_src_sel   = 1'b1;
                        load_tag_valid = 1'b1;
                        clear_dirty    = 1'b1;
                        state_d        = S_HITMISS;
                    end
                end
                default: begin
                    state_d = S_HITMISS;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HITMISS;
        end else begin
            state_q <= state_d;
        end
    end

    assign tmr_active = (state_q == S_WRITEBACK) || (state_q == S_FETCH);
    assign tmr_clear  = (state_d != state_q) || pmem_resp;

    pmem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (tmr_active),
        .clear   (tmr_clear),
        .expired (pmem_timeout)
    );

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM for the 2-way set-associative, write-back, write-allocate LC-3b cache.
- Sits upstream of the way/LRU load arbitrator. It drives that arbitrator's select (lru_or_way) and way_sel, plus all other datapath loads.
- Handshakes with the CPU on one side and physical memory on the other.
- Contains a cycle counter that watches for physical-memory wait timeouts.

Parameters:
MAX_WAIT, 255, cycles spent in a pmem state without pmem_resp before pmem_timeout sets (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  CPU request complete (combinational, one cycle)
hit0  in  1  way 0 valid and tag match for current set
hit1  in  1  way 1 valid and tag match for current set
lru_bit  in  1  LRU way of current set (1 = way 1)
lru_dirty  in  1  dirty bit of the LRU way of current set
pmem_resp  in  1  physical memory transfer complete
pmem_read  out  1  physical memory line read
pmem_write  out  1  physical memory line write
pmem_addr_sel  out  1  0 = CPU address, 1 = {LRU way tag, set} writeback address
lru_or_way  out  1  arbitrator select: 1 = way_sel path, 0 = lru_bit path
way_sel  out  1  way being written on a write hit
load_data  out  1  load data array (way chosen by arbitrator)
data_src_sel  out  1  0 = CPU write-merge data, 1 = pmem line
load_tag_valid  out  1  load tag and set valid in arbitrated way
set_dirty  out  1  set dirty in arbitrated way
clear_dirty  out  1  clear dirty in arbitrated way
load_lru  out  1  write LRU array
lru_in  out  1  new LRU value
pmem_timeout  out  1  sticky error flag

Behaviour:
- States: S_HITMISS (reset state), S_WRITEBACK, S_FETCH.
- Reset: async on rst_n=0. State goes to S_HITMISS, wait counter to 0, pmem_timeout to 0. All outputs are 0 while in reset, except lru_or_way=1.
- Default outputs are 0 in every state unless stated below.
- Request qualifier: req = mem_read | mem_write. If both are asserted, it is treated as a write.
- Hit: hit = hit0 | hit1. If both are set (illegal), way 0 is used.

S_HITMISS:
- lru_or_way=1.
- No req: no outputs, stay.
- req & hit: mem_resp=1 in the same cycle. load_lru=1 and lru_in = ~hitway, where hitway = hit1 & ~hit0.
- Write hit additionally: way_sel=hitway, load_data=1, data_src_sel=0, set_dirty=1.
- req & ~hit: next state S_WRITEBACK if lru_dirty, else S_FETCH. No mem_resp.

S_WRITEBACK:
- pmem_write=1, pmem_addr_sel=1, lru_or_way=0.
- On pmem_resp: clear_dirty=1, next state S_FETCH.

S_FETCH:
- pmem_read=1, pmem_addr_sel=0, lru_or_way=0.
- On pmem_resp: load_data=1, data_src_sel=1, load_tag_valid=1, clear_dirty=1, next state S_HITMISS.
- The CPU then hits on the following cycle.

Latency:
- Hit: 0 cycles (mem_resp in the request cycle).
- Clean miss: F + 2 cycles, where F = pmem latency.
- Dirty miss: W + F + 2 cycles, where W = writeback latency.

Wait counter:
- Clears on every state change and on pmem_resp. Increments each cycle in S_WRITEBACK/S_FETCH.
- Saturates at MAX_WAIT. Reaching MAX_WAIT sets pmem_timeout, which stays set until reset.
- The FSM keeps waiting; a timeout never aborts the transfer.

Boundary conditions:
- CPU drops req mid-miss: the line operation still completes and the FSM returns to S_HITMISS. No mem_resp is issued.
- pmem_resp while in S_HITMISS: ignored.
- Reset mid-transfer: pmem_read/pmem_write deassert immediately (async).
- lru_bit and lru_dirty are sampled combinationally each cycle. The datapath holds the address stable for the whole request.

Decomposition:
- lc3b_types: add a cache_state_t enum {S_HITMISS, S_WRITEBACK, S_FETCH}.
- Sub-module pmem_wait_timer, parameter MAX_WAIT:
  - inputs clk, rst_n, active, clear
  - output expired, sticky until reset
  - saturating counter sized $clog2(MAX_WAIT+1).

Test Plan:
- Reset then mem_read=1, hit1=1, lru_bit=1 -> same cycle mem_resp=1, load_lru=1, lru_in=0, load_data=0, pmem_read=0.
- mem_write=1, hit0=1 -> mem_resp=1, lru_or_way=1, way_sel=0, load_data=1, data_src_sel=0, set_dirty=1, lru_in=1.
- Clean read miss, lru_dirty=0, pmem_resp after 4 cycles:
  - S_FETCH entered next cycle, pmem_read=1 for 4 cycles.
  - On resp: load_data=1, data_src_sel=1, load_tag_valid=1, lru_or_way=0.
  - Hit forced next cycle -> mem_resp.
- Dirty write miss, lru_dirty=1:
  - pmem_write=1 and pmem_addr_sel=1 until resp, then clear_dirty=1.
  - S_FETCH pmem_read=1, then back to S_HITMISS, then write hit with set_dirty.
- MAX_WAIT=8, pmem_resp withheld in S_FETCH -> pmem_timeout=1 after 8 cycles and stays 1. Late pmem_resp still completes the fetch.
- rst_n low for 1 cycle mid-S_WRITEBACK -> pmem_write=0 immediately, state S_HITMISS, pmem_timeout=0. mem_read=1 with hit0=1 then gives mem_resp in the first cycle after reset.
